// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard receive controller.
//   Synchronises the raw PS/2 clock, deframes 11-bit frames (start, 8 data
//   LSB first, odd parity, stop), folds E0 (extended) and F0 (break) prefixes
//   into key events, and queues those events in a small FIFO drained through
//   a valid/ready port.
//   Optional feature macro: PS2_KBD_TIMEOUT_EN -- when defined, a frame that
//   stalls mid-way for TIMEOUT_CYC clk cycles is aborted and counted as an
//   error. When undefined, a partial frame waits indefinitely.
module ps2_kbd_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // ---------------------------------------------------------------------------
  // PS/2 clock synchroniser and falling-edge strobe
  // ---------------------------------------------------------------------------
  logic [2:0] ps2_clk_sync;
  logic       sample_stb;

  // Shift the raw PS/2 clock through three flops; idle line level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_sync <= 3'b111;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all flops
      // update together from the values present before the edge.
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
    end
  end

  // ps2_data is already stable around the PS/2 falling edge, so it is sampled
  // directly on the strobe without its own synchroniser.
  assign sample_stb = ps2_clk_sync[2] & ~ps2_clk_sync[1];

  // ---------------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------------
  logic [3:0] bit_cnt;
  logic [9:0] shift_buf;
  logic       byte_vld;
  logic [7:0] rx_byte;
  logic       frame_end;
  logic       frame_good;
  logic       frame_bad;
  logic       timeout;

  assign frame_end  = sample_stb && (bit_cnt == 4'd10);
  assign frame_good = ~shift_buf[0] & ps2_data & (^shift_buf[9:1]);
  assign frame_bad  = frame_end & ~frame_good;

  // Collect start+data+parity, then check the frame when the stop bit arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_buf <= '0;
      byte_vld  <= 1'b0;
      rx_byte   <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (timeout) begin
        bit_cnt <= '0;
      end else if (sample_stb) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_good) begin
            byte_vld <= 1'b1;
            rx_byte  <= shift_buf[8:1];
          end
        end else begin
          shift_buf[bit_cnt] <= ps2_data;
          bit_cnt            <= bit_cnt + 4'd1;
        end
      end
    end
  end

  // Saturating count of framing errors and aborted frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((frame_bad || timeout) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;

  // Count clk cycles since the last PS/2 edge while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (sample_stb || (bit_cnt == 4'd0) || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // A stop-bit strobe in the same cycle takes precedence over the abort.
  assign timeout = (bit_cnt != 4'd0) && (idle_cnt == TO_W'(TIMEOUT_CYC)) && !sample_stb;
`else
  // TIMEOUT_CYC has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  dec_state_t state_q;
  dec_state_t state_d;
  logic       push;
  kbd_evt_t   push_data;

  // Decoder state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and event emission; a bad or aborted frame drops any prefix.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    push      = 1'b0;
    push_data = '0;
    if (frame_bad || timeout) begin
      state_d = ST_IDLE;
    end else if (byte_vld) begin
      push_data.code = rx_byte;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == 8'hE0) begin
            state_d = ST_EXT;
          end else if (rx_byte == 8'hF0) begin
            state_d = ST_BRK;
          end else begin
            push = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (rx_byte == 8'hE0) begin
            state_d = ST_EXT;
          end else begin
            push          = 1'b1;
            push_data.ext = 1'b1;
            state_d       = ST_IDLE;
          end
        end
        ST_BRK: begin
          push          = 1'b1;
          push_data.brk = 1'b1;
          state_d       = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push          = 1'b1;
          push_data.ext = 1'b1;
          push_data.brk = 1'b1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  kbd_evt_t      fifo_mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_ok;
  logic          drop;
  kbd_evt_t      head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = evt_valid & evt_ready;
  assign push_ok    = push & (~fifo_full | pop);
  assign drop       = push & fifo_full & ~pop;

  // Storage and pointers; a full FIFO still accepts a push when a pop frees a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is reset too, so the head outputs read 0 after reset
      // and a reset discards any queued events outright.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed PS/2 frames, with expected
// events pushed to a scoreboard queue and compared as the DUT hands them out.
module tb_ps2_kbd_ctrl;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected events as {ext, brk, code}
  logic [9:0] sb_q [$];

  ps2_kbd_ctrl #(
    .DEPTH      (8),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_break(evt_break),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted events: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", {22'd0, evt_ext, evt_break, evt_code}, 32'h3FF);
      end else begin
        check("event", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, sb_q[0]});
        void'(sb_q.pop_front());
      end
    end
  end

  // One PS/2 bit: data set up, clock low long enough to be seen, clock high again.
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_parity);
    logic par;
    par = ~(^data) ^ bad_parity;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(data[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    sb_q.push_back({ext, brk, code});
  endtask

  // Bounded wait for all expected events to be consumed.
  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_ext", evt_ext, 0);
    check("rst_break", evt_break, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: plain make code
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_drain("t1_drain");
    check("t1_err_cnt", err_cnt, 0);

    // 2: break prefix yields a single release event
    expect_evt(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    wait_drain("t2_drain");

    // 3: extended break, then a plain code proves the decoder returned to idle
    expect_evt(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    wait_drain("t3_drain");
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_drain("t3_idle_drain");

    // 4: parity error is dropped and counted; the next good frame is clean
    send_frame(8'h1C, 1'b1);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_no_event", evt_valid, 0);
    expect_evt(1'b0, 1'b0, 8'h32);
    send_frame(8'h32, 1'b0);
    wait_drain("t4_drain");

    // 5: consumer stalled, nine makes into an eight-entry FIFO
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_evt(1'b0, 1'b0, 8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b0);
    end
    check("t5_valid", evt_valid, 1);
    check("t5_overflow", overflow, 1);
    check("t5_head_code", evt_code, 8'h10);
    check("t5_held", sb_q.size(), 8);
    ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    @(negedge clk);
    check("t5_ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_empty", evt_valid, 0);

    // 6: a frame stalled after four bits
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (150) @(negedge clk);
`ifdef PS2_KBD_TIMEOUT_EN
    check("t6_timeout_err", err_cnt, 2);
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_drain("t6_drain");
    check("t6_err_after", err_cnt, 2);
`else
    check("t6_no_timeout_err", err_cnt, 1);
    send_frame(8'h1C, 1'b0);
    check("t6_no_clean_event", evt_valid, 0);
`endif

    // Reset in the middle of a frame discards the partial frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_valid", evt_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    expect_evt(1'b0, 1'b0, 8'h32);
    send_frame(8'h32, 1'b0);
    wait_drain("mid_rst_drain");
    check("mid_rst_err_after", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
